// File: rtl/dbg_run_ctrl.sv
// Debug run controller: debounced step/select keys, free-run clock-enable divider
// and a PC breakpoint that halts free-run until the next single step.
module dbg_run_ctrl #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned RUN_DIV   = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        KEY_STEP,
  input  logic        KEY_SEL,
  input  logic        SW_RUN,
  input  logic        BRK_EN,
  input  logic [31:0] BRK_ADDR,
  input  logic [31:0] nextPC,
  output logic        CPU_CE,
  output logic        CHG,
  output logic        HALT,
  output logic [1:0]  STATE,
  output logic [15:0] STEP_CNT
);

  localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);
  localparam int unsigned DivW = $clog2(RUN_DIV);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StBrk  = 2'b10
  } state_e;

  // Bit 0 = step key, bit 1 = select key, bit 2 = run switch.
  logic [2:0]           sync1_q, sync2_q;
  logic [1:0]           deb_q, deb_d;
  logic [1:0][DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]           key_p_q, key_p_d;

  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic                 cpu_ce_q, cpu_ce_d;
  logic                 chg_q, chg_d;
  logic                 halt_q, halt_d;
  logic [15:0]          step_cnt_q, step_cnt_d;

  logic step_p, sel_p, run_s, brk_hit, div_last;

  assign step_p   = key_p_q[0];
  assign sel_p    = key_p_q[1];
  assign run_s    = sync2_q[2];
  assign brk_hit  = BRK_EN && (nextPC == BRK_ADDR);
  assign div_last = (div_q == DivW'(RUN_DIV - 1));

  // Level is accepted only after DB_CYCLES consecutive clocks of disagreement.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    key_p_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
          deb_d[i]   = ~deb_q[i];
          key_p_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cpu_ce_d = 1'b0;
    div_d    = '0;
    case (state_q)
      StIdle: begin
        if (step_p) cpu_ce_d = 1'b1;
        if (run_s)  state_d  = StRun;
      end
      StRun: begin
        div_d = div_last ? '0 : div_q + DivW'(1);
        if (!run_s) begin
          state_d = StIdle;
        end else if (div_last) begin
          if (brk_hit) state_d  = StBrk;
          else         cpu_ce_d = 1'b1;
        end
      end
      StBrk: begin
        if (step_p) begin
          cpu_ce_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    chg_d      = sel_p;
    halt_d     = (state_d == StBrk);
    step_cnt_d = step_cnt_q + 16'(cpu_ce_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      db_cnt_q   <= '0;
      key_p_q    <= '0;
      state_q    <= StIdle;
      div_q      <= '0;
      cpu_ce_q   <= 1'b0;
      chg_q      <= 1'b0;
      halt_q     <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      sync1_q    <= {SW_RUN, KEY_SEL, KEY_STEP};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      db_cnt_q   <= db_cnt_d;
      key_p_q    <= key_p_d;
      state_q    <= state_d;
      div_q      <= div_d;
      cpu_ce_q   <= cpu_ce_d;
      chg_q      <= chg_d;
      halt_q     <= halt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign CPU_CE   = cpu_ce_q;
  assign CHG      = chg_q;
  assign HALT     = halt_q;
  assign STATE    = state_q;
  assign STEP_CNT = step_cnt_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed scenarios plus a randomized free-run/breakpoint phase for dbg_run_ctrl.
module tb_dbg_run_ctrl;

  localparam int unsigned DbCycles = 4;
  localparam int unsigned RunDiv   = 5;
  localparam int unsigned KeyLat   = DbCycles + 3;
  localparam logic [31:0] BrkPc    = 32'h0040_0010;

  logic        clk = 1'b0;
  logic        rst, key_step, key_sel, sw_run, brk_en;
  logic [31:0] brk_addr, next_pc;
  logic        cpu_ce, chg, halt;
  logic [1:0]  state;
  logic [15:0] step_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  dbg_run_ctrl #(
    .DB_CYCLES(DbCycles),
    .RUN_DIV  (RunDiv)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .KEY_STEP(key_step),
    .KEY_SEL (key_sel),
    .SW_RUN  (sw_run),
    .BRK_EN  (brk_en),
    .BRK_ADDR(brk_addr),
    .nextPC  (next_pc),
    .CPU_CE  (cpu_ce),
    .CHG     (chg),
    .HALT    (halt),
    .STATE   (state),
    .STEP_CNT(step_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Press keys from IDLE, expect one pulse at KeyLat, then release with no pulse.
  task automatic press(input bit step, input bit sel);
    key_step = step;
    key_sel  = sel;
    for (int n = 1; n <= int'(KeyLat) + 2; n++) begin
      tick();
      check("press_ce", 32'(cpu_ce), 32'(step && n == int'(KeyLat)));
      check("press_chg", 32'(chg), 32'(sel && n == int'(KeyLat)));
      if (step && n == int'(KeyLat)) exp_cnt = (exp_cnt + 1) % 65536;
    end
    key_step = 1'b0;
    key_sel  = 1'b0;
    for (int n = 1; n <= int'(DbCycles) + 4; n++) begin
      tick();
      check("release_ce", 32'(cpu_ce), 32'd0);
      check("release_chg", 32'(chg), 32'd0);
    end
    check("press_cnt", 32'(step_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int  k;
    bit  hit;
    bit  exp_ce;
    int  exp_st;

    rst = 1'b1; key_step = 1'b0; key_sel = 1'b0; sw_run = 1'b0;
    brk_en = 1'b0; brk_addr = BrkPc; next_pc = 32'h0;
    #2;
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_chg", 32'(chg), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt", 32'(step_cnt), 32'd0);
    tick();
    rst = 1'b0;

    // Single step
    press(1'b1, 1'b0);
    check("step_state", 32'(state), 32'd0);
    check("step_cnt1", 32'(step_cnt), 32'd1);

    // Bounce never settles long enough
    for (int n = 0; n < 14; n++) begin
      key_step = (n < 4) ? ~n[0] : 1'b0;
      tick();
      check("bounce_ce", 32'(cpu_ce), 32'd0);
      check("bounce_chg", 32'(chg), 32'd0);
    end

    // Simultaneous keys, then select alone
    press(1'b1, 1'b1);
    press(1'b0, 1'b1);

    // Counter wrap: preload the counter, then step
    force dut.step_cnt_q = 16'hFFFF;
    #1;
    release dut.step_cnt_q;
    exp_cnt = 16'hFFFF;
    press(1'b1, 1'b0);
    check("wrap_cnt", 32'(step_cnt), 32'h0);

    // Free run: RUN after 3 edges, pulses every RunDiv edges after entry
    sw_run = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      exp_ce = (n >= 8) && ((n - 3) % int'(RunDiv) == 0);
      check("run_state", 32'(state), (n >= 3) ? 32'd1 : 32'd0);
      check("run_ce", 32'(cpu_ce), 32'(exp_ce));
      if (exp_ce) exp_cnt = (exp_cnt + 1) % 65536;
    end
    check("run_cnt4", 32'(step_cnt), 32'd4);

    // Breakpoint hits at the next divider terminal edge (edge 28)
    brk_en  = 1'b1;
    next_pc = BrkPc;
    for (int n = 25; n <= 31; n++) begin
      tick();
      check("brk_ce", 32'(cpu_ce), 32'd0);
      check("brk_state", 32'(state), (n >= 28) ? 32'd2 : 32'd1);
      check("brk_halt", 32'(halt), 32'(n >= 28));
    end
    // Step out of BRK, then SW_RUN re-enters RUN
    brk_en   = 1'b0;
    key_step = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      tick();
      check("brkstep_ce", 32'(cpu_ce), 32'(m == int'(KeyLat)));
      exp_st = (m < int'(KeyLat)) ? 2 : ((m == int'(KeyLat)) ? 0 : 1);
      check("brkstep_state", 32'(state), 32'(exp_st));
      check("brkstep_halt", 32'(halt), 32'(m < int'(KeyLat)));
    end
    exp_cnt  = exp_cnt + 1;
    key_step = 1'b0;
    for (int p = 1; p <= int'(RunDiv); p++) begin
      tick();
      check("rerun_ce", 32'(cpu_ce), 32'(p == int'(RunDiv)));
    end
    exp_cnt = exp_cnt + 1;
    check("rerun_cnt", 32'(step_cnt), 32'(exp_cnt));

    // Reset while CPU_CE is high; select key held through reset
    rst     = 1'b1;
    sw_run  = 1'b0;
    key_sel = 1'b1;
    #1;
    check("midrst_ce", 32'(cpu_ce), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_cnt", 32'(step_cnt), 32'd0);
    exp_cnt = 0;
    tick();
    rst = 1'b0;
    for (int n = 1; n <= int'(KeyLat) + 6; n++) begin
      if (n == int'(KeyLat) + 1) key_sel = 1'b0;
      tick();
      check("postrst_chg", 32'(chg), 32'(n == int'(KeyLat)));
      check("postrst_ce", 32'(cpu_ce), 32'd0);
      check("postrst_state", 32'(state), 32'd0);
    end

    // Randomized RUN phase: breakpoint only matters on divider terminal edges
    sw_run = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    check("rnd_entry", 32'(state), 32'd1);
    k = 0;
    for (int i = 0; i < 80; i++) begin
      brk_en  = 1'($urandom_range(0, 1));
      next_pc = ($urandom_range(0, 3) == 0) ? BrkPc : $urandom;
      hit     = brk_en && (next_pc == BrkPc);
      tick();
      k++;
      exp_ce = (k % int'(RunDiv) == 0) && !hit;
      exp_st = ((k % int'(RunDiv) == 0) && hit) ? 2 : 1;
      check("rnd_ce", 32'(cpu_ce), 32'(exp_ce));
      check("rnd_state", 32'(state), 32'(exp_st));
      check("rnd_halt", 32'(halt), 32'(exp_st == 2));
      if (exp_ce) exp_cnt = (exp_cnt + 1) % 65536;
      if (exp_st == 2) break;
    end
    check("rnd_cnt", 32'(step_cnt), 32'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
